// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back unit.
// Latches the MEM-stage instruction fields and results, then decodes the
// latched fields into the register-file write port consumed by ID.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, flush     instruction present / kill it this cycle
//   opcode, funct       instruction opcode and R-type function field
//   rt, rd              register fields
//   alu_result          ALU result / memory address
//   mem_rdata           aligned data-memory word
//   pc_plus4            PC+4 of the instruction (JAL link value)
//   wrt_dt, wrt_reg     register write data / address (qualify with reg_wrt)
//   reg_wrt             register write enable, one cycle per writing instr
//   misalign_err        misaligned halfword load (write suppressed)
//   retired_cnt         count of retired instructions, wraps
module wb_stage #(
    parameter int WORD_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5,
    parameter int LINK_REG      = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     flush,
    input  logic [5:0]               opcode,
    input  logic [5:0]               funct,
    input  logic [REGADDR_WIDTH-1:0] rt,
    input  logic [REGADDR_WIDTH-1:0] rd,
    input  logic [WORD_WIDTH-1:0]    alu_result,
    input  logic [WORD_WIDTH-1:0]    mem_rdata,
    input  logic [WORD_WIDTH-1:0]    pc_plus4,
    output logic [WORD_WIDTH-1:0]    wrt_dt,
    output logic [REGADDR_WIDTH-1:0] wrt_reg,
    output logic                     reg_wrt,
    output logic                     misalign_err,
    output logic [31:0]              retired_cnt
);

    logic                     valid_q, valid_d;
    logic [5:0]               opcode_q, funct_q;
    logic [REGADDR_WIDTH-1:0] rt_q, rd_q;
    logic [WORD_WIDTH-1:0]    alu_q, mem_q, pc4_q;
    logic [31:0]              cnt_q, cnt_d;

    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic                     dec_wen;
    logic                     dec_mis;
    logic [REGADDR_WIDTH-1:0] dec_reg;
    logic [WORD_WIDTH-1:0]    dec_dt;

    // Retirement is counted on the capturing edge, so a flushed slot never counts.
    always_comb begin
        valid_d = in_valid & ~flush;
        cnt_d   = cnt_q;
        if (valid_d) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Reset clears every field so the decoded outputs are all zero too.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            funct_q  <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            alu_q    <= '0;
            mem_q    <= '0;
            pc4_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode;
            funct_q  <= funct;
            rt_q     <= rt;
            rd_q     <= rd;
            alu_q    <= alu_result;
            mem_q    <= mem_rdata;
            pc4_q    <= pc_plus4;
            cnt_q    <= cnt_d;
        end
    end

    // Big-endian sub-word selection: offset 0 is the most significant byte.
    always_comb begin
        byte_sel = mem_q[7:0];
        case (alu_q[1:0])
            2'b00:   byte_sel = mem_q[31:24];
            2'b01:   byte_sel = mem_q[23:16];
            2'b10:   byte_sel = mem_q[15:8];
            default: byte_sel = mem_q[7:0];
        endcase
        half_sel = alu_q[1] ? mem_q[15:0] : mem_q[31:16];
    end

    always_comb begin
        dec_wen = 1'b0;
        dec_mis = 1'b0;
        dec_reg = rt_q;
        dec_dt  = alu_q;
        case (opcode_q)
            6'h00: begin
                dec_reg = rd_q;
                dec_wen = (funct_q != 6'h08);
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                dec_wen = 1'b1;
            end
            6'h23: begin
                dec_dt  = mem_q;
                dec_wen = 1'b1;
            end
            6'h20, 6'h24: begin
                dec_dt  = {{(WORD_WIDTH-8){(opcode_q == 6'h20) & byte_sel[7]}}, byte_sel};
                dec_wen = 1'b1;
            end
            6'h21, 6'h25: begin
                dec_dt  = {{(WORD_WIDTH-16){(opcode_q == 6'h21) & half_sel[15]}}, half_sel};
                dec_wen = ~alu_q[0];
                dec_mis = alu_q[0];
            end
            6'h03: begin
                dec_reg = REGADDR_WIDTH'(LINK_REG);
                dec_dt  = pc4_q;
                dec_wen = 1'b1;
            end
            default: begin
                dec_wen = 1'b0;
            end
        endcase
    end

    assign wrt_dt       = dec_dt;
    assign wrt_reg      = dec_reg;
    assign reg_wrt      = valid_q & dec_wen & (dec_reg != '0);
    assign misalign_err = valid_q & dec_mis;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic [31:0] wrt_dt;
    logic [4:0]  wrt_reg;
    logic        reg_wrt;
    logic        misalign_err;
    logic [31:0] retired_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    wb_stage #(
        .WORD_WIDTH(32),
        .REGADDR_WIDTH(5),
        .LINK_REG(31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .flush(flush),
        .opcode(opcode),
        .funct(funct),
        .rt(rt),
        .rd(rd),
        .alu_result(alu_result),
        .mem_rdata(mem_rdata),
        .pc_plus4(pc_plus4),
        .wrt_dt(wrt_dt),
        .wrt_reg(wrt_reg),
        .reg_wrt(reg_wrt),
        .misalign_err(misalign_err),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        fl;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic        e_wrt;
        logic        e_mis;
        logic        chk;    // compare wrt_reg/wrt_dt (only meaningful on writes)
        logic [4:0]  e_reg;
        logic [31:0] e_dt;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] t, input logic [4:0] d, input logic [31:0] a,
                         input logic [31:0] m, input logic [31:0] p);
        in_valid   = v;
        flush      = fl;
        opcode     = op;
        funct      = fn;
        rt         = t;
        rd         = d;
        alu_result = a;
        mem_rdata  = m;
        pc_plus4   = p;
    endtask

    initial begin
        //           v  fl op     fn     rt  rd  alu           mem           pc4           wrt mis chk reg dt            cnt
        vecs[0]  = '{1, 0, 6'h00, 6'h20, 0,  5,  32'h0000_1234, 32'h0,        32'h0,        1,  0,  1,  5,  32'h0000_1234, 1};
        vecs[1]  = '{1, 0, 6'h20, 6'h00, 8,  0,  32'h0000_0100, 32'h80FF_7F01, 32'h0,       1,  0,  1,  8,  32'hFFFF_FF80, 2};
        vecs[2]  = '{1, 0, 6'h24, 6'h00, 8,  0,  32'h0000_0102, 32'h80FF_7F01, 32'h0,       1,  0,  1,  8,  32'h0000_007F, 3};
        vecs[3]  = '{1, 0, 6'h21, 6'h00, 9,  0,  32'h0000_0102, 32'h1234_F00D, 32'h0,       1,  0,  1,  9,  32'hFFFF_F00D, 4};
        vecs[4]  = '{1, 0, 6'h25, 6'h00, 9,  0,  32'h0000_0101, 32'h1234_F00D, 32'h0,       0,  1,  0,  9,  32'h0,         5};
        vecs[5]  = '{1, 0, 6'h03, 6'h00, 2,  0,  32'h0,         32'h0,        32'h0040_0010, 1, 0,  1,  31, 32'h0040_0010, 6};
        vecs[6]  = '{1, 0, 6'h08, 6'h00, 0,  0,  32'h0000_0055, 32'h0,        32'h0,        0,  0,  1,  0,  32'h0000_0055, 7};
        vecs[7]  = '{1, 0, 6'h00, 6'h20, 0,  3,  32'h0000_00AA, 32'h0,        32'h0,        1,  0,  1,  3,  32'h0000_00AA, 8};
        vecs[8]  = '{1, 0, 6'h2B, 6'h00, 4,  0,  32'h0000_0040, 32'h0,        32'h0,        0,  0,  0,  0,  32'h0,         9};
        vecs[9]  = '{1, 1, 6'h23, 6'h00, 6,  0,  32'h0000_0080, 32'h1111_2222, 32'h0,       0,  0,  0,  0,  32'h0,         9};
        vecs[10] = '{1, 0, 6'h00, 6'h08, 0,  0,  32'h0000_0300, 32'h0,        32'h0,        0,  0,  0,  0,  32'h0,         10};
        vecs[11] = '{1, 0, 6'h0D, 6'h00, 7,  0,  32'h0000_0F0F, 32'h0,        32'h0,        1,  0,  1,  7,  32'h0000_0F0F, 11};
        vecs[12] = '{1, 0, 6'h23, 6'h00, 10, 0,  32'h0000_0203, 32'hDEAD_BEEF, 32'h0,       1,  0,  1,  10, 32'hDEAD_BEEF, 12};
        vecs[13] = '{1, 0, 6'h20, 6'h00, 12, 0,  32'h0000_0103, 32'h80FF_7F01, 32'h0,       1,  0,  1,  12, 32'h0000_0001, 13};
        vecs[14] = '{0, 0, 6'h00, 6'h20, 0,  13, 32'h0000_0777, 32'h0,        32'h0,        0,  0,  0,  0,  32'h0,         13};
        vecs[15] = '{1, 0, 6'h25, 6'h00, 11, 0,  32'h0000_0100, 32'h8001_1234, 32'h0,       1,  0,  1,  11, 32'h0000_8001, 14};
        vecs[16] = '{1, 0, 6'h21, 6'h00, 11, 0,  32'h0000_0100, 32'h8001_1234, 32'h0,       1,  0,  1,  11, 32'hFFFF_8001, 15};

        // Reset held two cycles while a valid ADD is presented.
        rst = 1'b1;
        drive(1, 0, 6'h00, 6'h20, 0, 5, 32'h1234, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_reg_wrt", {31'd0, reg_wrt}, 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);
        check("rst_wrt_dt", wrt_dt, 32'd0);
        check("rst_wrt_reg", {27'd0, wrt_reg}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].fl, vecs[i].op, vecs[i].fn, vecs[i].rt, vecs[i].rd,
                  vecs[i].alu, vecs[i].mem, vecs[i].pc4);
            @(negedge clk);
            check($sformatf("v%0d_reg_wrt", i), {31'd0, reg_wrt}, {31'd0, vecs[i].e_wrt});
            check($sformatf("v%0d_misalign", i), {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
            check($sformatf("v%0d_cnt", i), retired_cnt, vecs[i].e_cnt);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_wrt_reg", i), {27'd0, wrt_reg}, {27'd0, vecs[i].e_reg});
                check($sformatf("v%0d_wrt_dt", i), wrt_dt, vecs[i].e_dt);
            end
        end

        // The last table entry wrote; with a bubble next the write must drop.
        drive(0, 0, 6'h00, 6'h20, 0, 5, 32'h1, 32'h0, 32'h0);
        @(negedge clk);
        check("pulse_end_reg_wrt", {31'd0, reg_wrt}, 32'd0);
        check("pulse_end_cnt", retired_cnt, 32'd15);

        // Flush kills the new slot but the stage's current instruction still writes.
        drive(1, 0, 6'h00, 6'h20, 0, 6, 32'h66, 32'h0, 32'h0);
        @(negedge clk);
        drive(1, 1, 6'h00, 6'h20, 0, 7, 32'h77, 32'h0, 32'h0);
        check("flush_prev_reg_wrt", {31'd0, reg_wrt}, 32'd1);
        check("flush_prev_wrt_reg", {27'd0, wrt_reg}, 32'd6);
        @(negedge clk);
        check("flush_bubble_reg_wrt", {31'd0, reg_wrt}, 32'd0);
        check("flush_cnt", retired_cnt, 32'd16);

        // Instruction latched, then reset asserted: no write after reset edge.
        drive(1, 0, 6'h00, 6'h20, 0, 9, 32'h99, 32'h0, 32'h0);
        @(negedge clk);
        check("pre_rst_reg_wrt", {31'd0, reg_wrt}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_reg_wrt", {31'd0, reg_wrt}, 32'd0);
        check("mid_rst_cnt", retired_cnt, 32'd0);
        rst = 1'b0;
        drive(0, 0, 6'h00, 6'h00, 0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("post_rst_reg_wrt", {31'd0, reg_wrt}, 32'd0);

        // Counter wrap: preload all ones, then retire one instruction.
        force dut.cnt_q = 32'hFFFF_FFFF;
        drive(1, 0, 6'h00, 6'h20, 0, 4, 32'h44, 32'h0, 32'h0);
        #1;
        release dut.cnt_q;
        check("wrap_preload", retired_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wrap_cnt", retired_cnt, 32'd0);
        check("wrap_reg_wrt", {31'd0, reg_wrt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and write-back unit for the MIPS datapath.
- Latches the instruction fields and results arriving from the MEM stage, then selects and formats the write data.
- Chooses the destination register and drives the register-file write port (wrt_dt, wrt_reg, reg_wrt) that the ID stage consumes.
- Also counts retired instructions and flags misaligned loads.

Parameters:
- WORD_WIDTH, 32, datapath width.
- REGADDR_WIDTH, 5, register address width.
- LINK_REG, 31, destination register for JAL.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  MEM stage presents a real instruction this cycle
- flush  in  1  kill the instruction presented this cycle
- opcode  in  6  instruction opcode
- funct  in  6  R-type function field
- rt  in  5  rt field
- rd  in  5  rd field
- alu_result  in  32  ALU result / memory address
- mem_rdata  in  32  aligned data-memory word
- pc_plus4  in  32  PC+4 of the instruction
- wrt_dt  out  32  register write data
- wrt_reg  out  5  register write address
- reg_wrt  out  1  register write enable
- misalign_err  out  1  misaligned halfword load, write suppressed
- retired_cnt  out  32  count of retired instructions

Behaviour:
- Reset: while rst=1 at a rising edge, the stage clears valid, and all outputs go to 0 on that edge: wrt_dt=0, wrt_reg=0, reg_wrt=0, misalign_err=0, retired_cnt=0. Reset overrides in_valid and flush.
- Capture: at each rising edge the stage loads valid <= in_valid & ~flush, together with all input fields. With no valid instruction the stage holds a bubble: reg_wrt=0 and misalign_err=0.
- Latency: an instruction presented at edge N drives its outputs during cycle N+1 only. reg_wrt is high for exactly one cycle per writing instruction, because the ID register file writes level-sensitively.
- Decode (from latched fields):
  - opcode 0x00, funct != 0x08 (not JR): dest rd, data alu_result.
  - opcode 0x00, funct 0x08 (JR): no write.
  - opcodes 0x08-0x0F (ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI): dest rt, data alu_result.
  - 0x23 LW: dest rt, data mem_rdata.
  - 0x20 LB / 0x24 LBU: dest rt; big-endian byte select on alu_result[1:0] (00 selects bits 31:24, 11 selects bits 7:0); LB sign-extends, LBU zero-extends.
  - 0x21 LH / 0x25 LHU: dest rt; alu_result[1]=0 selects bits 31:16, =1 selects bits 15:0; LH sign-extends, LHU zero-extends.
  - 0x03 JAL: dest LINK_REG, data pc_plus4 (no delay slot).
  - Every other opcode (stores, branches, J, unknown): no write.
- Misalignment:
  - LH/LHU with alu_result[0]=1: reg_wrt=0 and misalign_err=1 for that one cycle.
  - LW ignores alu_result[1:0]; memory supplies the aligned word.
- Register zero: if the destination decodes to 0, reg_wrt=0. wrt_reg and wrt_dt still show the decoded values.
- Non-writing cycles: wrt_reg and wrt_dt carry the decoded (don't-care) values; consumers qualify them with reg_wrt.
- retired_cnt: increments by 1 on the edge that captures a valid instruction, including non-writing and misaligned ones. Wraps from 0xFFFFFFFF to 0.
- Flush: a flush asserted together with in_valid inserts a bubble. It does not affect the instruction already in the stage.
- Reset mid-stream: an instruction latched before reset never produces a write after reset asserts.

Test Plan:
- Reset held 2 cycles with in_valid=1 -> reg_wrt=0, retired_cnt=0. After release, ADD (op 0, funct 0x20, rd=5, alu_result=0x1234) -> next cycle reg_wrt=1, wrt_reg=5, wrt_dt=0x1234, retired_cnt=1.
- LB, rt=8, mem_rdata=0x80FF7F01, alu_result[1:0]=00 -> wrt_dt=0xFFFFFF80. Same with LBU and alu_result[1:0]=10 -> wrt_dt=0x0000007F.
- LH, alu_result=0x102, mem_rdata=0x1234F00D -> wrt_dt=0xFFFFF00D. LHU with alu_result=0x101 -> reg_wrt=0, misalign_err=1 for one cycle.
- JAL, pc_plus4=0x0040_0010 -> wrt_reg=31, wrt_dt=0x00400010. ADDI with rt=0 -> reg_wrt=0, retired_cnt still increments.
- Back-to-back ADD, SW, flushed LW, JR, ORI -> reg_wrt pattern 1,0,0,0,1 over consecutive cycles; retired_cnt advances by 4.
- Preload retired_cnt to 0xFFFFFFFF (force), then one valid instruction -> retired_cnt=0.
